// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg -- shared definitions for the seven-segment capture path.
//   * digit count, nibble / segment / index widths
//   * the 16 standard hex glyphs, active-high, bit 0 = segment a ... bit 6 = g
//   * capture FSM state enum
// -----------------------------------------------------------------------------
package seg_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int NIB_W      = 4;
   localparam int SEG_W      = 7;
   localparam int IDX_W      = 3;

   //                               gfedcba
   localparam logic [6:0] GLYPH_0 = 7'b0111111;
   localparam logic [6:0] GLYPH_1 = 7'b0000110;
   localparam logic [6:0] GLYPH_2 = 7'b1011011;
   localparam logic [6:0] GLYPH_3 = 7'b1001111;
   localparam logic [6:0] GLYPH_4 = 7'b1100110;
   localparam logic [6:0] GLYPH_5 = 7'b1101101;
   localparam logic [6:0] GLYPH_6 = 7'b1111101;
   localparam logic [6:0] GLYPH_7 = 7'b0000111;
   localparam logic [6:0] GLYPH_8 = 7'b1111111;
   localparam logic [6:0] GLYPH_9 = 7'b1101111;
   localparam logic [6:0] GLYPH_A = 7'b1110111;
   localparam logic [6:0] GLYPH_B = 7'b1111100;
   localparam logic [6:0] GLYPH_C = 7'b0111001;
   localparam logic [6:0] GLYPH_D = 7'b1011110;
   localparam logic [6:0] GLYPH_E = 7'b1111001;
   localparam logic [6:0] GLYPH_F = 7'b1110001;

   // Indexed by nibble value.
   localparam logic [15:0][6:0] GLYPHS = {
      GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
      GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
   };

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_e;

endpackage

// File: rtl/seg_capture_if.sv
// -----------------------------------------------------------------------------
// seg_capture_if -- pin and result bundle of the seven-segment capture block.
//   Driver side : AN (digit enables), C (segments a..g), DP (decimal point)
//   Result side : value, valid, err, cap_stb, cap_idx, frame_stb
//                 dp (only when SEG_CAPTURE_DP_EN is defined)
//   modport slave  : the capture block (samples pins, drives results)
//   modport master : whoever drives the pins and consumes the results
// -----------------------------------------------------------------------------
interface seg_capture_if;
   import seg_pkg::*;

   logic [NUM_DIGITS-1:0]       AN;
   logic [SEG_W-1:0]            C;
   logic                        DP;
   logic [NUM_DIGITS*NIB_W-1:0] value;
   logic [NUM_DIGITS-1:0]       valid;
   logic [NUM_DIGITS-1:0]       err;
   logic                        cap_stb;
   logic [IDX_W-1:0]            cap_idx;
   logic                        frame_stb;
`ifdef SEG_CAPTURE_DP_EN
   logic [NUM_DIGITS-1:0]       dp;
`endif

   modport slave (
      input  AN, C, DP,
      output value, valid, err, cap_stb, cap_idx, frame_stb
`ifdef SEG_CAPTURE_DP_EN
      , output dp
`endif
   );

   modport master (
      output AN, C, DP,
      input  value, valid, err, cap_stb, cap_idx, frame_stb
`ifdef SEG_CAPTURE_DP_EN
      , input dp
`endif
   );

endinterface

// File: rtl/seg7_to_hex.sv
// -----------------------------------------------------------------------------
// seg7_to_hex -- combinational glyph to nibble decoder, inverse of the
// hex->segment encoder.
//   seg_i : active-high glyph, bit 0 = a ... bit 6 = g
//   nib_o : decoded nibble (0 for an unknown glyph)
//   bad_o : glyph is not one of the 16 hex glyphs
// -----------------------------------------------------------------------------
module seg7_to_hex
   import seg_pkg::*;
(
   input  logic [SEG_W-1:0] seg_i,
   output logic [NIB_W-1:0] nib_o,
   output logic             bad_o
);

   // Glyphs are unique, so at most one entry can match.
   always_comb begin
      nib_o = '0;
      bad_o = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (seg_i == GLYPHS[i]) begin
            nib_o = NIB_W'(i);
            bad_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg_capture.sv
// -----------------------------------------------------------------------------
// seg_capture -- samples a multiplexed seven-segment drive, waits for each
// digit to settle and rebuilds the 8-digit hex value shown.
//   clk, rst : single clock, asynchronous active-high reset
//   bus      : seg_capture_if.slave
//              in  AN[7:0], C[6:0], DP
//              out value[31:0], valid[7:0], err[7:0], cap_stb, cap_idx[2:0],
//                  frame_stb, dp[7:0] (dp only with SEG_CAPTURE_DP_EN)
// Parameters:
//   SETTLE_CYCLES : identical synchronized samples needed for a capture (1..255)
//   ACTIVE_LOW    : 1 = AN/C/DP are active-low on the pins
// Build option:
//   SEG_CAPTURE_DP_EN : capture decimal points; DP also takes part in stability
// -----------------------------------------------------------------------------
module seg_capture
   import seg_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   seg_capture_if.slave bus
);

   localparam logic [7:0]            SETTLE_N = 8'(SETTLE_CYCLES);
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic [SEG_W-1:0]      C_OFF    = {SEG_W{ACTIVE_LOW}};
`ifdef SEG_CAPTURE_DP_EN
   localparam int SAMP_W = NUM_DIGITS + SEG_W + 1;
`else
   localparam int SAMP_W = NUM_DIGITS + SEG_W;
`endif

   // ---------------- synchronizer (resets to the inactive pin level) --------
   logic [NUM_DIGITS-1:0] an_s1_q, an_s2_q;
   logic [SEG_W-1:0]      c_s1_q,  c_s2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_s1_q <= AN_OFF;
         an_s2_q <= AN_OFF;
         c_s1_q  <= C_OFF;
         c_s2_q  <= C_OFF;
      end else begin
         an_s1_q <= bus.AN;
         an_s2_q <= an_s1_q;
         c_s1_q  <= bus.C;
         c_s2_q  <= c_s1_q;
      end
   end

   logic [NUM_DIGITS-1:0] an_n;
   logic [SEG_W-1:0]      c_n;
   logic [SAMP_W-1:0]     samp;

   assign an_n = an_s2_q ^ AN_OFF;
   assign c_n  = c_s2_q ^ C_OFF;

`ifdef SEG_CAPTURE_DP_EN
   logic dp_s1_q, dp_s2_q, dp_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_s1_q <= ACTIVE_LOW;
         dp_s2_q <= ACTIVE_LOW;
      end else begin
         dp_s1_q <= bus.DP;
         dp_s2_q <= dp_s1_q;
      end
   end

   assign dp_n = dp_s2_q ^ ACTIVE_LOW;
   assign samp = {an_n, c_n, dp_n};
`else
   assign samp = {an_n, c_n};
`endif

   // ---------------- stability tracking -------------------------------------
   // samp_q is the previous normalized sample; it resets to all-inactive so a
   // pin pattern that is still idle after reset is not seen as a change.
   logic [SAMP_W-1:0] samp_q;
   logic [7:0]        cnt_q, cnt_d;
   state_e            state_q, state_d;
   logic              chg, decide, cap;
   logic [7:0]        run;

   assign chg = (samp != samp_q);

   // run = length of the identical-sample streak including the current
   // sample. Counting the current sample lets the decision land on the edge
   // 2 + SETTLE_CYCLES after the pin change, even for SETTLE_CYCLES = 1.
   assign run = chg                 ? 8'd1 :
                (cnt_q >= SETTLE_N) ? SETTLE_N : cnt_q + 8'd1;

   // A fresh change only decides on its own when one sample is enough.
   assign decide = (run == SETTLE_N) && ((state_q == SETTLE) || chg);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap     = 1'b0;
      case (state_q)
         IDLE, HOLD: begin
            if (chg) begin
               state_d = SETTLE;
               cnt_d   = run;
            end
         end
         SETTLE: cnt_d = run;
         default: state_d = IDLE;
      endcase
      if (decide) begin
         if ($onehot(an_n)) begin
            cap     = 1'b1;
            state_d = HOLD;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         samp_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         samp_q  <= samp;
      end
   end

   // ---------------- decode and result registers ----------------------------
   logic [IDX_W-1:0] idx;
   logic [NIB_W-1:0] nib;
   logic             bad;

   always_comb begin
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (an_n[i]) idx = IDX_W'(i);
      end
   end

   seg7_to_hex u_dec (
      .seg_i (c_n),
      .nib_o (nib),
      .bad_o (bad)
   );

   logic [NUM_DIGITS*NIB_W-1:0] value_q, value_d;
   logic [NUM_DIGITS-1:0]       valid_q, valid_d;
   logic [NUM_DIGITS-1:0]       err_q,   err_d;
   logic [IDX_W-1:0]            cap_idx_q, cap_idx_d;
   logic                        cap_stb_q, frame_q, frame_d;

   always_comb begin
      value_d   = value_q;
      err_d     = err_q;
      cap_idx_d = cap_idx_q;
      frame_d   = 1'b0;
      // valid is cleared the edge after a completed frame
      valid_d   = frame_q ? '0 : valid_q;
      if (cap) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
               value_d[i*NIB_W +: NIB_W] = nib;
               err_d[i]                  = bad;
               valid_d[i]                = 1'b1;
            end
         end
         cap_idx_d = idx;
         frame_d   = &valid_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q   <= '0;
         valid_q   <= '0;
         err_q     <= '0;
         cap_idx_q <= '0;
         cap_stb_q <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         value_q   <= value_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         cap_idx_q <= cap_idx_d;
         cap_stb_q <= cap;
         frame_q   <= frame_d;
      end
   end

   assign bus.value     = value_q;
   assign bus.valid     = valid_q;
   assign bus.err       = err_q;
   assign bus.cap_idx   = cap_idx_q;
   assign bus.cap_stb   = cap_stb_q;
   assign bus.frame_stb = frame_q;

`ifdef SEG_CAPTURE_DP_EN
   logic [NUM_DIGITS-1:0] dp_q, dp_d;

   always_comb begin
      dp_d = dp_q;
      if (cap) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) dp_d[i] = dp_n;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) dp_q <= '0;
      else     dp_q <= dp_d;
   end

   assign bus.dp = dp_q;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// -----------------------------------------------------------------------------
// tb_seg_capture -- directed bench for seg_capture, ACTIVE_LOW=1,
// SETTLE_CYCLES=4 (capture expected 6 cycles after a pin change).
// -----------------------------------------------------------------------------
module tb_seg_capture;
   import seg_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seg_capture_if bus ();

   seg_capture #(.SETTLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0]  an;
      logic [6:0]  c;
      int          hold;
      bit          cap;
      logic [2:0]  idx;
      bit          frame;
      logic [31:0] value;
      logic [7:0]  valid;
      logic [7:0]  err;
   } vec_t;

   vec_t tv[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Runs n cycles; returns first cap_stb cycle, number of cap_stb cycles
   // and the cycle frame_stb was seen (0 = never).
   task automatic watch(input int n, output int lat, output int ncap, output int fcyc);
      lat  = 0;
      ncap = 0;
      fcyc = 0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.cap_stb === 1'b1) begin
            ncap++;
            if (lat == 0) lat = k;
         end
         if (bus.frame_stb === 1'b1 && fcyc == 0) fcyc = k;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_value"}, bus.value, 32'h0);
      chk({tag, "_valid"}, {24'h0, bus.valid}, 32'h0);
      chk({tag, "_err"},   {24'h0, bus.err}, 32'h0);
      chk({tag, "_idx"},   {29'h0, bus.cap_idx}, 32'h0);
      chk({tag, "_stb"},   {31'h0, bus.cap_stb}, 32'h0);
      chk({tag, "_frame"}, {31'h0, bus.frame_stb}, 32'h0);
`ifdef SEG_CAPTURE_DP_EN
      chk({tag, "_dp"},    {24'h0, bus.dp}, 32'h0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, ncap, fcyc, tot;

      //          an     c           hold cap idx fr value         valid  err
      tv[0]  = '{8'hFE, 7'b1111001, 10, 1, 0, 0, 32'h00000001, 8'h01, 8'h00};
      tv[1]  = '{8'hFE, 7'b1000000, 10, 1, 0, 0, 32'h00000000, 8'h01, 8'h00};
      tv[2]  = '{8'hFD, 7'b1111001, 10, 1, 1, 0, 32'h00000010, 8'h03, 8'h00};
      tv[3]  = '{8'hFB, 7'b0100100, 10, 1, 2, 0, 32'h00000210, 8'h07, 8'h00};
      tv[4]  = '{8'hF7, 7'b0110000, 10, 1, 3, 0, 32'h00003210, 8'h0F, 8'h00};
      tv[5]  = '{8'hEF, 7'b0011001, 10, 1, 4, 0, 32'h00043210, 8'h1F, 8'h00};
      tv[6]  = '{8'hDF, 7'b0010010, 10, 1, 5, 0, 32'h00543210, 8'h3F, 8'h00};
      tv[7]  = '{8'hBF, 7'b0000010, 10, 1, 6, 0, 32'h06543210, 8'h7F, 8'h00};
      tv[8]  = '{8'h7F, 7'b1111000, 10, 1, 7, 1, 32'h76543210, 8'h00, 8'h00};
      tv[9]  = '{8'hFC, 7'b1111001, 20, 0, 7, 0, 32'h76543210, 8'h00, 8'h00};
      tv[10] = '{8'hFB, 7'b0110110, 10, 1, 2, 0, 32'h76543010, 8'h04, 8'h04};
      tv[11] = '{8'hFB, 7'b0001000, 10, 1, 2, 0, 32'h76543A10, 8'h04, 8'h00};

      rst    = 1'b1;
      bus.AN = 8'hFF;
      bus.C  = 7'h7F;
      bus.DP = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      // ---------------- table ----------------
      foreach (tv[i]) begin
         bus.AN = tv[i].an;
         bus.C  = tv[i].c;
         watch(tv[i].hold, lat, ncap, fcyc);
         chk($sformatf("v%0d_ncap", i), ncap, {31'h0, tv[i].cap});
         if (tv[i].cap) chk($sformatf("v%0d_lat", i), lat, 6);
         else chk($sformatf("v%0d_state", i), 32'(dut.state_q), 32'(IDLE));
         chk($sformatf("v%0d_frame", i), fcyc, tv[i].frame ? 6 : 0);
         chk($sformatf("v%0d_idx", i), {29'h0, bus.cap_idx}, {29'h0, tv[i].idx});
         chk($sformatf("v%0d_value", i), bus.value, tv[i].value);
         chk($sformatf("v%0d_valid", i), {24'h0, bus.valid}, {24'h0, tv[i].valid});
         chk($sformatf("v%0d_err", i), {24'h0, bus.err}, {24'h0, tv[i].err});
      end

      // ---------------- C toggling every 3 cycles never settles ------------
      bus.AN = 8'hF7;
      tot = 0;
      for (int k = 0; k < 5; k++) begin
         bus.C = k[0] ? 7'b0010000 : 7'b0000000;
         watch(3, lat, ncap, fcyc);
         tot += ncap;
      end
      chk("toggle_nocap", tot, 0);
      bus.C = 7'b0010000;
      watch(10, lat, ncap, fcyc);
      chk("toggle_ncap", ncap, 1);
      chk("toggle_lat", lat, 6);
      chk("toggle_value", bus.value, 32'h76549A10);
      chk("toggle_valid", {24'h0, bus.valid}, 32'h0C);

      // ---------------- reset during SETTLE with valid=0F --------------------
      bus.AN = 8'hFE; bus.C = 7'b1000000;
      watch(10, lat, ncap, fcyc);
      bus.AN = 8'hFD; bus.C = 7'b1111001;
      watch(10, lat, ncap, fcyc);
      chk("pre_rst_valid", {24'h0, bus.valid}, 32'h0F);
      chk("pre_rst_value", bus.value, 32'h76549A10);
      bus.AN = 8'hEF; bus.C = 7'b0011001;
      watch(3, lat, ncap, fcyc);
      chk("settle_nocap", ncap, 0);
      #2 rst = 1'b1;
      #1 chk_zero("rst_settle");
      watch(3, lat, ncap, fcyc);
      chk("rst_settle_pulse", ncap + fcyc, 0);
      rst = 1'b0;

      // first capture after release needs the full sync + settle
      watch(10, lat, ncap, fcyc);
      chk("rel_ncap", ncap, 1);
      chk("rel_lat", lat, 6);
      chk("rel_value", bus.value, 32'h00040000);
      chk("rel_valid", {24'h0, bus.valid}, 32'h10);
      chk("rel_idx", {29'h0, bus.cap_idx}, 32'h4);

      // ---------------- reset during HOLD ----------------------------------
      #2 rst = 1'b1;
      #1 chk_zero("rst_hold");
      watch(3, lat, ncap, fcyc);
      chk("rst_hold_pulse", ncap + fcyc, 0);

      // ---------------- DP-only change -----------------------------------
      rst    = 1'b0;
      bus.AN = 8'hDF; bus.C = 7'b0010010; bus.DP = 1'b1;
      watch(3, lat, ncap, fcyc);
      chk("dp_pre_nocap", ncap, 0);
      bus.DP = 1'b0;
      watch(10, lat, ncap, fcyc);
      chk("dp_ncap", ncap, 1);
      chk("dp_value", bus.value, 32'h00500000);
`ifdef SEG_CAPTURE_DP_EN
      // DP change restarts the settle count
      chk("dp_lat", lat, 6);
      chk("dp_bits", {24'h0, bus.dp}, 32'h20);
`else
      // DP ignored: capture follows the AN/C change made 3 cycles earlier
      chk("dp_lat", lat, 3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
